// File: rtl/ex_stage_unit.sv
// ex_stage_unit: execute stage of the pipeline.
// Consumes the 58-bit ID/EX bundle, runs the ALU command and registers a 38-bit
// EX/MEM bundle. MUL is an iterative shift-add that holds ex_busy high while it runs.
// Optional feature macro: EX_OVERFLOW_EN (adds ex_overflow and suppresses the
// write-back/mem-write enables of an ADD/SUB that overflows).
module ex_stage_unit #(
    parameter int DATA_W     = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [57:0] in_word,
    input  logic        in_valid,
    input  logic        flush,
    output logic        ex_busy,
    output logic [37:0] out_word,
    output logic        out_valid
`ifdef EX_OVERFLOW_EN
    ,
    output logic        ex_overflow
`endif
);

    localparam int CNT_W = $clog2(MUL_CYCLES);
    localparam int SH_W  = $clog2(DATA_W);

    localparam logic [3:0] CMD_NOP = 4'h0;
    localparam logic [3:0] CMD_ADD = 4'h1;
    localparam logic [3:0] CMD_SUB = 4'h2;
    localparam logic [3:0] CMD_AND = 4'h3;
    localparam logic [3:0] CMD_OR  = 4'h4;
    localparam logic [3:0] CMD_XOR = 4'h5;
    localparam logic [3:0] CMD_NOR = 4'h6;
    localparam logic [3:0] CMD_SLL = 4'h7;
    localparam logic [3:0] CMD_SRL = 4'h8;
    localparam logic [3:0] CMD_SRA = 4'h9;
    localparam logic [3:0] CMD_MUL = 4'hA;
    localparam logic [3:0] CMD_SLT = 4'hB;

    typedef enum logic {
        S_IDLE,
        S_MUL_RUN
    } state_t;

    // Unpacked ID/EX fields
    logic [3:0]        cmd;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [21:0]       side_in;
    logic [SH_W-1:0]   shamt;

    assign cmd     = in_word[57:54];
    assign src1    = in_word[53:38];
    assign src2    = in_word[37:22];
    assign side_in = in_word[21:0];
    assign shamt   = src2[SH_W-1:0];

    // Architectural state
    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] prod_q;
    logic [21:0]       side_q;
    logic [37:0]       out_word_q;
    logic              out_valid_q;
`ifdef EX_OVERFLOW_EN
    logic              ovf_q;
`endif

    // Combinational next values
    logic [DATA_W-1:0] alu_res;
    logic [21:0]       side_d;
    logic              ovf_d;
    logic [DATA_W-1:0] prod_d;

    // Single-cycle ALU result plus (optional) overflow detection on ADD/SUB
    always_comb begin
        alu_res = '0;
        ovf_d   = 1'b0;
        side_d  = side_in;
        unique case (cmd)
            CMD_NOP: alu_res = src1;
            CMD_ADD: alu_res = src1 + src2;
            CMD_SUB: alu_res = src1 - src2;
            CMD_AND: alu_res = src1 & src2;
            CMD_OR:  alu_res = src1 | src2;
            CMD_XOR: alu_res = src1 ^ src2;
            CMD_NOR: alu_res = ~(src1 | src2);
            CMD_SLL: alu_res = src1 << shamt;
            CMD_SRL: alu_res = src1 >> shamt;
            CMD_SRA: alu_res = $signed(src1) >>> shamt;
            CMD_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1) < $signed(src2))};
            default: alu_res = '0;
        endcase
`ifdef EX_OVERFLOW_EN
        if (cmd == CMD_ADD)
            ovf_d = (src1[DATA_W-1] == src2[DATA_W-1]) && (alu_res[DATA_W-1] != src1[DATA_W-1]);
        else if (cmd == CMD_SUB)
            ovf_d = (src1[DATA_W-1] != src2[DATA_W-1]) && (alu_res[DATA_W-1] != src1[DATA_W-1]);
        if (ovf_d) begin
            side_d[21] = 1'b0;
            side_d[4]  = 1'b0;
        end
`endif
    end

    // One shift-add step: accumulate the shifted multiplicand when the multiplier LSB is set
    always_comb begin
        prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Control FSM with registered EX/MEM outputs; flush outranks everything but reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            side_q      <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef EX_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else if (flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef EX_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
`ifdef EX_OVERFLOW_EN
            ovf_q <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid && cmd == CMD_MUL) begin
                        state_q     <= S_MUL_RUN;
                        cnt_q       <= '0;
                        mcand_q     <= src1;
                        mplier_q    <= src2;
                        prod_q      <= '0;
                        side_q      <= side_in;
                        out_word_q  <= '0;
                        out_valid_q <= 1'b0;
                    end else if (in_valid) begin
                        out_word_q  <= {alu_res, side_d};
                        out_valid_q <= 1'b1;
`ifdef EX_OVERFLOW_EN
                        ovf_q       <= ovf_d;
`endif
                    end else begin
                        out_word_q  <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
                S_MUL_RUN: begin
                    prod_q   <= prod_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                        state_q     <= S_IDLE;
                        cnt_q       <= '0;
                        out_word_q  <= {prod_d, side_q};
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q       <= cnt_q + CNT_W'(1);
                        out_word_q  <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_word_q  <= '0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ex_busy   = (state_q == S_MUL_RUN);
    assign out_word  = out_word_q;
    assign out_valid = out_valid_q;
`ifdef EX_OVERFLOW_EN
    assign ex_overflow = ovf_q;
`endif

endmodule
